hd_clk_div_drv: RTL and testbench

Programmable clock-source cell model that produces a registered divided clock, CKO, from the master clock CK. CKO feeds the clock-load and antenna cells at the leaf end of the modelled clock tree, so this block is the driving end of the net those cells terminate. It supports glitch-free ratio changes and glitch-free stop/start through an EN/LOAD/ACK control interface. It is used in xsim gate-level clock-tree fault experiments.

---
 rtl/hd_clkdrv_pkg.sv | 16 +
 rtl/hd_clkdrv_cnt.sv | 45 ++++
 rtl/hd_clk_div_drv.sv | 137 +++++++++++++
 tb/tb_hd_clk_div_drv.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_clkdrv_pkg.sv
// Shared types and helpers for the hd_clk_div_drv divided-clock source.
package hd_clkdrv_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned MIN_DIV_DEF = 2;

   // High-phase length of an N-cycle period: ceil(N/2), odd N gets the extra cycle.
   function automatic logic [31:0] half_up(input logic [31:0] n);
      return (n >> 1) + {31'd0, n[0]};
   endfunction

endpackage

// File: rtl/hd_clkdrv_cnt.sv
// Period counter: counts 0..N-1 while enabled and flags the last and high-phase cycles.
module hd_clkdrv_cnt
   import hd_clkdrv_pkg::*;
#(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] n,
   output logic [DIV_W-1:0] cnt,
   output logic             last,
   output logic             high
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic [DIV_W-1:0] h;

   always_comb begin
      h     = DIV_W'(half_up(32'(n)));
      last  = (cnt_q == (n - ONE));
      high  = (cnt_q < h);
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = last ? '0 : (cnt_q + ONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hd_clk_div_drv.sv
// Programmable divided-clock source with glitch-free ratio change and stop/start.
module hd_clk_div_drv
   import hd_clkdrv_pkg::*;
#(
   parameter int unsigned DIV_W   = 8,
   parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
   input  logic             CK,
   input  logic             RN,
   input  logic             EN,
   input  logic [DIV_W-1:0] DIV,
   input  logic             LOAD,
   output logic             ACK,
   output logic             CKO,
   output logic             TICK,
   output logic             BUSY
);

   localparam logic [DIV_W-1:0] MIN_N = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] act_q, act_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             cko_q, cko_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;

   logic [DIV_W-1:0] div_n;
   logic [DIV_W-1:0] h;
   logic [DIV_W-1:0] cnt;
   logic             last;
   logic             high;
   logic             cnt_clr;
   logic             cnt_en;

   assign div_n   = (DIV < MIN_N) ? MIN_N : DIV;
   assign h       = DIV_W'(half_up(32'(act_q)));
   assign cnt_clr = (state_q == IDLE);
   assign cnt_en  = (state_q == RUN);

   hd_clkdrv_cnt #(
      .DIV_W (DIV_W)
   ) u_cnt (
      .clk    (CK),
      .rst_n  (RN),
      .clear  (cnt_clr),
      .enable (cnt_en),
      .n      (act_q),
      .cnt    (cnt),
      .last   (last),
      .high   (high)
   );

   always_comb begin
      state_d    = state_q;
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cko_d      = 1'b0;
      tick_d     = 1'b0;
      ack_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (LOAD) begin
               act_d = div_n;
               ack_d = 1'b1;
            end
            if (EN) begin
               state_d = RUN;
               cko_d   = 1'b1;
               tick_d  = 1'b1;
            end
         end
         RUN: begin
            if (!last) begin
               // cnt+1 < H expressed as (cnt < H) && (cnt != H-1), reusing the counter's high flag.
               cko_d = high && (cnt != (h - ONE));
               if (LOAD) begin
                  pend_d     = div_n;
                  pend_vld_d = 1'b1;
               end
            end else begin
               if (LOAD) begin
                  act_d      = div_n;
                  ack_d      = 1'b1;
                  pend_vld_d = 1'b0;
               end else if (pend_vld_q) begin
                  act_d      = pend_q;
                  ack_d      = 1'b1;
                  pend_vld_d = 1'b0;
               end
               if (EN) begin
                  cko_d  = 1'b1;
                  tick_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q    <= IDLE;
         act_q      <= MIN_N;
         pend_q     <= MIN_N;
         pend_vld_q <= 1'b0;
         cko_q      <= 1'b0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_q      <= act_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cko_q      <= cko_d;
         tick_q     <= tick_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

   assign CKO  = cko_q;
   assign TICK = tick_q;
   assign ACK  = ack_q;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_hd_clk_div_drv.sv
// Self-checking bench for hd_clk_div_drv: vector table, directed corner sequences, random run vs. period-queue model.
module tb_hd_clk_div_drv;

   localparam int unsigned DIV_W   = 8;
   localparam int          MIN_DIV = 2;

   logic             CK   = 1'b0;
   logic             RN   = 1'b0;
   logic             EN   = 1'b0;
   logic             LOAD = 1'b0;
   logic [DIV_W-1:0] DIV  = '0;
   logic             ACK, CKO, TICK, BUSY;

   int passed = 0;
   int total  = 0;

   hd_clk_div_drv #(
      .DIV_W   (DIV_W),
      .MIN_DIV (MIN_DIV)
   ) dut (
      .CK   (CK),
      .RN   (RN),
      .EN   (EN),
      .DIV  (DIV),
      .LOAD (LOAD),
      .ACK  (ACK),
      .CKO  (CKO),
      .TICK (TICK),
      .BUSY (BUSY)
   );

   always #5 CK = ~CK;

   // Reference model: each period is queued as its full CKO waveform when it starts.
   bit m_run;
   int m_act;
   int m_pend;
   bit m_pv;
   bit m_q[$];
   bit m_cko, m_tick, m_ack;

   function automatic int clampn(input int d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

   function automatic void m_reset();
      m_run  = 1'b0;
      m_act  = MIN_DIV;
      m_pend = MIN_DIV;
      m_pv   = 1'b0;
      m_q.delete();
      m_cko  = 1'b0;
      m_tick = 1'b0;
      m_ack  = 1'b0;
   endfunction

   function automatic void m_start();
      m_q.delete();
      for (int i = 0; i < m_act; i++) m_q.push_back(i < (m_act + 1) / 2);
      m_cko  = m_q.pop_front();
      m_tick = 1'b1;
   endfunction

   function automatic void m_step(input bit en, input bit ld, input int d);
      m_tick = 1'b0;
      m_ack  = 1'b0;
      if (!m_run) begin
         m_cko = 1'b0;
         if (ld) begin
            m_act = clampn(d);
            m_ack = 1'b1;
         end
         if (en) begin
            m_run = 1'b1;
            m_start();
         end
      end else if (m_q.size() != 0) begin
         if (ld) begin
            m_pend = clampn(d);
            m_pv   = 1'b1;
         end
         m_cko = m_q.pop_front();
      end else begin
         if (ld) begin
            m_act = clampn(d);
            m_ack = 1'b1;
            m_pv  = 1'b0;
         end else if (m_pv) begin
            m_act = m_pend;
            m_ack = 1'b1;
            m_pv  = 1'b0;
         end
         if (en) m_start();
         else begin
            m_run = 1'b0;
            m_cko = 1'b0;
         end
      end
   endfunction

   task automatic step(input bit en, input bit ld, input int d);
      EN   = en;
      LOAD = ld;
      DIV  = DIV_W'(d);
      @(posedge CK);
      m_step(en, ld, d);
      #1;
   endtask

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
      else passed++;
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      total++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      else passed++;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".CKO"},  CKO,  m_cko);
      chk({tag, ".TICK"}, TICK, m_tick);
      chk({tag, ".ACK"},  ACK,  m_ack);
      chk({tag, ".BUSY"}, BUSY, m_run);
   endtask

   typedef struct {
      bit en;
      bit ld;
      int div;
      bit cko;
      bit tick;
      bit ack;
      bit busy;
   } vec_t;

   function automatic vec_t mk(input bit en, input bit ld, input int div,
                               input bit cko, input bit tick, input bit ack, input bit busy);
      vec_t v;
      v.en = en; v.ld = ld; v.div = div;
      v.cko = cko; v.tick = tick; v.ack = ack; v.busy = busy;
      return v;
   endfunction

   vec_t tbl[19];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      int ackc;
      int guard;

      //            en ld div  cko tick ack busy
      tbl[0]  = mk(0, 1, 4,   0, 0, 1, 0);  // LOAD in IDLE: ACK next cycle
      tbl[1]  = mk(1, 0, 0,   1, 1, 0, 1);  // start, N=4
      tbl[2]  = mk(1, 0, 0,   1, 0, 0, 1);
      tbl[3]  = mk(1, 0, 0,   0, 0, 0, 1);
      tbl[4]  = mk(1, 0, 0,   0, 0, 0, 1);
      tbl[5]  = mk(1, 0, 0,   1, 1, 0, 1);
      tbl[6]  = mk(1, 0, 0,   1, 0, 0, 1);
      tbl[7]  = mk(1, 0, 0,   0, 0, 0, 1);
      tbl[8]  = mk(1, 0, 0,   0, 0, 0, 1);
      tbl[9]  = mk(1, 0, 0,   1, 1, 0, 1);
      tbl[10] = mk(1, 1, 5,   1, 0, 0, 1);  // pending N=5
      tbl[11] = mk(1, 0, 0,   0, 0, 0, 1);
      tbl[12] = mk(1, 0, 0,   0, 0, 0, 1);
      tbl[13] = mk(1, 0, 0,   1, 1, 1, 1);  // N=5 takes effect
      tbl[14] = mk(1, 0, 0,   1, 0, 0, 1);
      tbl[15] = mk(1, 0, 0,   1, 0, 0, 1);
      tbl[16] = mk(1, 0, 0,   0, 0, 0, 1);
      tbl[17] = mk(1, 0, 0,   0, 0, 0, 1);
      tbl[18] = mk(1, 0, 0,   1, 1, 0, 1);

      m_reset();
      #1;
      chk("reset.CKO",  CKO,  1'b0);
      chk("reset.TICK", TICK, 1'b0);
      chk("reset.ACK",  ACK,  1'b0);
      chk("reset.BUSY", BUSY, 1'b0);
      RN = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].ld, tbl[i].div);
         chk($sformatf("vec%0d.CKO", i),  CKO,  tbl[i].cko);
         chk($sformatf("vec%0d.TICK", i), TICK, tbl[i].tick);
         chk($sformatf("vec%0d.ACK", i),  ACK,  tbl[i].ack);
         chk($sformatf("vec%0d.BUSY", i), BUSY, tbl[i].busy);
      end

      // DIV=0 and DIV=1 clamp to N=2
      step(1, 1, 0);
      chk_model("div0");
      for (int i = 0; i < 8; i++) begin step(1, 0, 0); chk_model("div0"); end
      step(1, 1, 1);
      chk_model("div1");
      for (int i = 0; i < 6; i++) begin step(1, 0, 0); chk_model("div1"); end

      // Drain to IDLE, then N=6 with EN dropped at cnt=1
      guard = 0;
      while (m_run && guard < 20) begin step(0, 0, 0); chk_model("drain"); guard++; end
      chk_int("drain.bound", guard < 20, 1);
      step(0, 1, 6);
      chk_model("stop.load");
      step(1, 0, 0);
      chk_model("stop.c0");
      for (int i = 0; i < 5; i++) begin step(0, 0, 0); chk_model("stop.run"); end
      step(0, 0, 0);
      chk_model("stop.end");
      chk("stop.BUSY", BUSY, 1'b0);
      chk("stop.CKO",  CKO,  1'b0);
      step(0, 0, 0);
      chk_model("stop.idle");
      step(1, 0, 0);
      chk_model("restart");
      chk("restart.TICK", TICK, 1'b1);

      // Two LOADs in one N=8 period: single ACK, new period N=7
      guard = 0;
      while (m_run && guard < 20) begin step(0, 0, 0); chk_model("drain2"); guard++; end
      step(0, 1, 8);
      chk_model("dbl.load");
      step(1, 0, 0);
      chk_model("dbl.c0");
      ackc = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 2)      step(1, 1, 3);
         else if (c == 4) step(1, 1, 7);
         else             step(1, 0, 0);
         chk_model("dbl.run");
         if (ACK) ackc++;
      end
      for (int c = 1; c <= 7; c++) begin
         step(1, 0, 0);
         chk_model("dbl.n7");
         if (ACK) ackc++;
      end
      chk_int("dbl.ack_count", ackc, 1);
      chk("dbl.n7_tick", TICK, 1'b1);

      // Async reset mid-period while CKO=1, with a ratio pending
      step(1, 1, 9);
      chk_model("rst.pend");
      chk("rst.pre_CKO", CKO, 1'b1);
      #2;
      RN = 1'b0;
      #1;
      chk("rst.CKO",  CKO,  1'b0);
      chk("rst.BUSY", BUSY, 1'b0);
      chk("rst.ACK",  ACK,  1'b0);
      m_reset();
      #1;
      RN = 1'b1;
      step(0, 0, 0);
      chk_model("rst.idle");
      for (int i = 0; i < 6; i++) begin step(1, 0, 0); chk_model("rst.min"); end

      // Randomized run against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 12));
         chk_model($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
